trim_sweep_gen: RTL
===================

TRIM_SWEEP_GEN -- requirements
Module: trim_sweep_gen

Interface
REQ-001 Parameter CODE_W, default 12: trim code width in bits; CODE_W >= 2.
REQ-002 Parameter DIV_MAX, default 25000000: CLK50 cycles per bit period; even, DIV_MAX >= 2.
REQ-003 Parameter DWELL_TICKS, default 4: bit periods of settle time after each latch; DWELL_TICKS >= 1.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 CLK50  in  1  system clock; all logic on its rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 START  in  1  request to begin a run, sampled only in IDLE.
REQ-008 STOP  in  1  synchronous abort.
REQ-009 MODE  in  1  run mode: 0 = single code, 1 = sweep; sampled with START.
REQ-010 CODE_IN  in  CODE_W  first code of the run; sampled with START.
REQ-011 CODE_END  in  CODE_W  last sweep code; sampled with START.
REQ-012 TRIMCODE  out  CODE_W  code currently being applied.
REQ-013 DOUT  out  1  serial data, MSB first.
REQ-014 ENCLK  out  1  serial strobe; the receiver samples DOUT on its rising edge.
REQ-015 LATCH  out  1  high for the one bit period after the last bit of each code.
REQ-016 BUSY  out  1  high whenever the state is not IDLE.
REQ-017 DONE  out  1  one-cycle pulse at normal end of run.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 Divider: counter div_cnt runs 0..DIV_MAX-1 while BUSY.
  - Cleared to 0 on START acceptance.
  - Tick = one cycle where div_cnt == DIV_MAX-1.
  - State advances only on tick, except START and STOP.
REQ-020 States: IDLE, LOAD, SHIFT, LATCH, DWELL.
REQ-021 IDLE: START=1 and STOP=0 -> next cycle:
  - TRIMCODE=CODE_IN.
  - MODE and CODE_END captured.
  - BUSY=1.
  - state LOAD.
REQ-022 LOAD lasts 1 bit period; on tick:
  - shift register loads TRIMCODE.
  - DOUT = TRIMCODE[CODE_W-1].
  - state SHIFT.
REQ-023 SHIFT lasts exactly CODE_W bit periods. Each tick presents the next lower bit on DOUT. After the bit-0 period: DOUT=0, state LATCH.
REQ-024 ENCLK SHALL be 1 only in SHIFT, for cycles with div_cnt in [DIV_MAX/2, DIV_MAX-1] (second half of each bit); otherwise 0; ENCLK=0 in all other states.
REQ-025 LATCH state lasts 1 bit period with LATCH=1; on tick: LATCH=0, state DWELL.
REQ-026 DWELL lasts DWELL_TICKS bit periods; on its final tick:
  - If MODE=1 and TRIMCODE != CODE_END: TRIMCODE = TRIMCODE+1 modulo 2^CODE_W, state LOAD.
  - Otherwise: DONE=1 for one cycle, BUSY=0, state IDLE.
REQ-027 Sweep with CODE_END < CODE_IN SHALL wrap from 2^CODE_W-1 to 0 and continue to CODE_END. Sweep with CODE_END == CODE_IN SHALL send one code.
REQ-028 Total run length SHALL be N*(CODE_W+2+DWELL_TICKS)*DIV_MAX cycles from START acceptance to DONE, where N = number of codes sent.
REQ-029 START while BUSY SHALL be ignored; MODE, CODE_IN and CODE_END changes mid-run SHALL have no effect.
REQ-030 STOP=1 in any non-IDLE state -> next cycle:
  - state IDLE; DOUT=0, ENCLK=0, LATCH=0, BUSY=0.
  - no DONE pulse.
  - TRIMCODE holds its last value.
REQ-031 STOP and START asserted together in IDLE: STOP wins; the block SHALL stay in IDLE.

Reset
REQ-032 RST=1 SHALL force:
  - state IDLE, div_cnt=0, shift register=0.
  - TRIMCODE=0, DOUT=0, ENCLK=0, LATCH=0, BUSY=0, DONE=0.
  RST SHALL take priority over START and STOP.
REQ-033 RST asserted mid-run SHALL abort with no DONE pulse; the next START SHALL begin a fresh run.

Verification (DIV_MAX=4, CODE_W=12, DWELL_TICKS=4)
REQ-034 Single code: MODE=0, CODE_IN=12'hA5C, START pulse -> ENCLK rising-edge samples of DOUT read 1010_0101_1100; LATCH high 4 cycles; DONE 72 cycles after START acceptance.
REQ-035 Sweep: MODE=1, CODE_IN=12'h0FE, CODE_END=12'h100 -> codes 0FE, 0FF, 100 sent in order; DONE after 216 cycles.
REQ-036 Wrap: MODE=1, CODE_IN=12'hFFF, CODE_END=12'h001 -> codes FFF, 000, 001 sent; DONE after 216 cycles.
REQ-037 Abort: STOP asserted during the 5th SHIFT bit -> next cycle BUSY=0, DOUT=0, ENCLK=0, no DONE; TRIMCODE unchanged.
REQ-038 START re-pulsed mid-run is ignored; simultaneous START+STOP in IDLE keeps BUSY=0; RST mid-sweep returns all outputs to 0 on the next cycle.

Source files
------------

// File: rtl/trim_sweep_gen.sv
// trim_sweep_gen: serial trim-code shifter with latch, dwell and optional wrapping sweep
module trim_sweep_gen #(
  parameter int CODE_W      = 12,
  parameter int DIV_MAX     = 25000000,
  parameter int DWELL_TICKS = 4
) (
  input  logic              CLK50,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic              MODE,
  input  logic [CODE_W-1:0] CODE_IN,
  input  logic [CODE_W-1:0] CODE_END,
  output logic [CODE_W-1:0] TRIMCODE,
  output logic              DOUT,
  output logic              ENCLK,
  output logic              LATCH,
  output logic              BUSY,
  output logic              DONE
);
  localparam int DW = $clog2(DIV_MAX);
  localparam int PW = $clog2(CODE_W + DWELL_TICKS + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_DWELL} state_t;
  state_t state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [CODE_W-1:0] shreg, shreg_n, trim_n, code_end_r;
  logic mode_r, tick, start_ok, more, last_bit, last_dwell, enclk_n, done_n;
  assign tick       = state != S_IDLE && div_cnt == DW'(DIV_MAX - 1);
  assign start_ok   = state == S_IDLE && START && !STOP;
  assign more       = mode_r && TRIMCODE != code_end_r;
  assign last_bit   = pcnt == PW'(CODE_W - 1);
  assign last_dwell = pcnt == PW'(DWELL_TICKS - 1);
  assign DOUT       = shreg[CODE_W-1];
  always_ff @(posedge CLK50)
    if (RST) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == S_IDLE ? (start_ok ? S_LOAD : S_IDLE) :
              STOP            ? S_IDLE :
              !tick           ? state :
              state == S_LOAD  ? S_SHIFT :
              state == S_SHIFT ? (last_bit ? S_LATCH : S_SHIFT) :
              state == S_LATCH ? S_DWELL :
              !last_dwell      ? S_DWELL :
              more             ? S_LOAD : S_IDLE;
  end
  // next values for every register, so all outputs leave straight from flops
  always_comb begin
    div_n   = (state == S_IDLE || STOP || tick) ? '0 : div_cnt + 1'b1;
    pcnt_n  = state_n != state ? '0 : tick ? pcnt + 1'b1 : pcnt;
    shreg_n = state_n == S_IDLE ? '0 :
              (state == S_LOAD && tick) ? TRIMCODE :
              (state == S_SHIFT && tick) ? shreg << 1 : shreg;
    trim_n  = start_ok ? CODE_IN :
              (state == S_DWELL && state_n == S_LOAD) ? TRIMCODE + 1'b1 : TRIMCODE;
    enclk_n = state_n == S_SHIFT && div_n >= DW'(DIV_MAX / 2);
    done_n  = state == S_DWELL && state_n == S_IDLE && !STOP;
  end
  always_ff @(posedge CLK50)
    if (RST) begin
      div_cnt    <= '0;
      pcnt       <= '0;
      shreg      <= '0;
      TRIMCODE   <= '0;
      code_end_r <= '0;
      mode_r     <= 1'b0;
      ENCLK      <= 1'b0;
      LATCH      <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      div_cnt    <= div_n;
      pcnt       <= pcnt_n;
      shreg      <= shreg_n;
      TRIMCODE   <= trim_n;
      code_end_r <= start_ok ? CODE_END : code_end_r;
      mode_r     <= start_ok ? MODE : mode_r;
      ENCLK      <= enclk_n;
      LATCH      <= state_n == S_LATCH;
      BUSY       <= state_n != S_IDLE;
      DONE       <= done_n;
    end
endmodule
